// File: rtl/uart_pkg.sv
// Purpose : shared types and constants for the memory-mapped 8N1 UART receiver.
// Latency : n/a (types, constants and one pure helper function only).
// Backpr. : n/a.
// Contents:
//   state_e                 receiver FSM states
//   ADDR_DATA/ADDR_STATUS   bus register offsets
//   ST_*                    STATUS register bit positions
//   pack_status()           assembles the STATUS word from its fields
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Register offsets on the 1-bit address bus
  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  // STATUS register layout
  localparam int ST_VALID   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_FERR    = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 5;  // bits [8:4]; wide enough for a 16-entry count

  // Every bit not named above reads as zero.
  function automatic logic [31:0] pack_status(
    input logic                valid,
    input logic                full,
    input logic                ovr,
    input logic                ferr,
    input logic [ST_CNT_W-1:0] cnt
  );
    logic [31:0] s;
    s                          = '0;
    s[ST_VALID]                = valid;
    s[ST_FULL]                 = full;
    s[ST_OVR]                  = ovr;
    s[ST_FERR]                 = ferr;
    s[ST_CNT_LSB +: ST_CNT_W]  = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Purpose : small synchronous FIFO holding received bytes until the CPU reads them.
// Latency : push visible in o_count/o_empty the cycle after the push edge; o_pop_dat is the
//           head entry, combinational from the registered read pointer.
// Backpr. : a push into a full FIFO with no pop in the same cycle is dropped and pulses
//           o_ovf; push+pop while full both proceed; pop while empty is ignored.
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_push, i_push_dat     write strobe and byte
//   i_pop                  read strobe (advances the head)
//   o_pop_dat              current head byte (undefined content when empty)
//   o_full, o_empty        occupancy flags
//   o_count                number of stored entries, 0..DEPTH
//   o_ovf                  single-cycle pulse for a dropped push
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_dat,
  input  logic                       i_pop,
  output logic [W-1:0]               o_pop_dat,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [NW-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == NW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rptr];

  // A pop frees a slot in the same edge, so a push into a full FIFO is
  // accepted whenever it coincides with a real pop.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_ovf     = i_push & o_full & ~w_do_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_dat;
  end

endmodule

// File: rtl/uart_rx_port.sv
// Purpose : memory-mapped 8N1 UART receiver: rx synchronizer, bit-timing FSM, byte FIFO,
//           DATA/STATUS read port and a level interrupt for pending data.
// Latency : byte available ~2 + DIV/2 + 9*DIV cycles after the rx falling edge; bus_rd in
//           cycle N returns o_bus_rdata in cycle N+1.
// Backpr. : none on rx; bytes arriving with the FIFO full (and no same-cycle DATA read)
//           are dropped and latch the overrun flag.
// Ports:
//   i_clk, i_rst_n         system clock, async active-low reset
//   i_rx                   asynchronous serial input, idle high
//   i_bus_rd, i_bus_addr   one-cycle read strobe; address 0 = DATA, 1 = STATUS
//   o_bus_rdata            registered read data, held between reads
//   o_irq                  high while the FIFO holds at least one byte
module uart_rx_port
  import uart_pkg::*;
#(
  parameter int DIV   = 278,  // clock cycles per bit, >= 4
  parameter int DEPTH = 4     // FIFO entries, power of two in 2..16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  input  logic        i_bus_rd,
  input  logic        i_bus_addr,
  output logic [31:0] o_bus_rdata,
  output logic        o_irq
);

  localparam int CW = $clog2(DIV);
  localparam int NW = $clog2(DEPTH) + 1;

  // First tick lands in the middle of the start bit; later ticks are one bit apart.
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

  // ---------------------------------------------------------------------------
  // Synchronizer: reset to the idle (high) level so a reset never fakes a start bit.
  // ---------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitidx;
  logic [7:0]    r_shreg;

  logic w_tick;
  logic w_stop_tick;
  logic w_push;
  logic w_ferr_set;

  assign w_tick      = (r_cnt == '0);
  assign w_stop_tick = (r_state == STOP) && w_tick;
  // The push is taken straight from the stop-bit sample so the byte lands in the
  // FIFO on the same edge the stop bit is judged.
  assign w_push      = w_stop_tick &&  w_rx_s;
  assign w_ferr_set  = w_stop_tick && !w_rx_s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bitidx <= '0;
      r_shreg  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_cnt   <= HALF_LOAD;
            r_state <= START;
          end
        end

        START: begin
          if (w_tick) begin
            if (!w_rx_s) begin
              r_cnt    <= FULL_LOAD;
              r_bitidx <= '0;
              r_state  <= DATA;
            end else begin
              // Line went back high by mid start bit: treat as a glitch.
              r_state  <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        DATA: begin
          if (w_tick) begin
            r_shreg  <= {w_rx_s, r_shreg[7:1]};  // LSB arrives first
            r_cnt    <= FULL_LOAD;
            r_bitidx <= r_bitidx + 1'b1;
            if (r_bitidx == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        STOP: begin
          // Return to IDLE at mid stop bit so a back-to-back start edge is not missed.
          if (w_tick) r_state <= IDLE;
          else        r_cnt   <= r_cnt - 1'b1;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic [NW-1:0] w_count;
  logic          w_ovf;
  logic          w_pop;
  logic          w_rd_data;
  logic          w_rd_status;

  assign w_rd_data   = i_bus_rd && (i_bus_addr == ADDR_DATA);
  assign w_rd_status = i_bus_rd && (i_bus_addr == ADDR_STATUS);
  assign w_pop       = w_rd_data && !w_empty;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .i_push_dat (r_shreg),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_ovf      (w_ovf)
  );

  // ---------------------------------------------------------------------------
  // Sticky error flags. A STATUS read clears them, but an error arriving on the
  // same edge wins so it is never lost between two reads.
  // ---------------------------------------------------------------------------
  logic r_ovr;
  logic r_ferr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovr  <= w_ovf      | (r_ovr  & ~w_rd_status);
      r_ferr <= w_ferr_set | (r_ferr & ~w_rd_status);
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: registered data, held between accesses. STATUS returns the
  // pre-edge flags, i.e. the values being cleared.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bus_rdata <= '0;
    end else if (i_bus_rd) begin
      if (i_bus_addr == ADDR_DATA) begin
        o_bus_rdata <= w_empty ? 32'd0 : {24'd0, w_head};
      end else begin
        o_bus_rdata <= pack_status(!w_empty, w_full, r_ovr, r_ferr, ST_CNT_W'(w_count));
      end
    end
  end

  assign o_irq = (w_count != '0);

endmodule

// File: tb/tb_uart_rx_port.sv
module tb_uart_rx_port;

  localparam int DIV   = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        bus_rd;
  logic        bus_addr;
  logic [31:0] bus_rdata;
  logic        irq;

  always #5 clk = ~clk;

  uart_rx_port #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .i_bus_rd    (bus_rd),
    .i_bus_addr  (bus_addr),
    .o_bus_rdata (bus_rdata),
    .o_irq       (irq)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected read responses
  logic [31:0] exp_q[$];

  // Reference model: the receiver as seen by software
  logic [7:0] mq[$];
  bit         m_ovr  = 1'b0;
  bit         m_ferr = 1'b0;

  int t_frame_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result of a bus read, with its side effects on the model.
  function automatic logic [31:0] model_read(input logic addr);
    logic [31:0] r;
    int          n;
    n = mq.size();
    if (addr == 1'b0) begin
      r = 32'd0;
      if (n > 0) r = {24'd0, mq.pop_front()};
    end else begin
      r = 32'(n * 16 + (m_ferr ? 8 : 0) + (m_ovr ? 4 : 0) +
              (n == DEPTH ? 2 : 0) + (n != 0 ? 1 : 0));
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end
    return r;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)               m_ferr = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(b);
    else                        m_ovr = 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic addr);
    exp_q.push_back(model_read(addr));
    bus_rd   = 1'b1;
    bus_addr = addr;
    step();
    bus_rd   = 1'b0;
  endtask

  // Drives one 8N1 frame; rd_at > 0 issues a DATA read sampled on edge rd_at of the frame.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int rd_at);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    t_frame_start = cyc;
    for (int k = 0; k < 10 * DIV; k++) begin
      rx = bits[k / DIV];
      if (k == rd_at - 1) begin
        exp_q.push_back(model_read(1'b0));
        bus_rd   = 1'b1;
        bus_addr = 1'b0;
      end else begin
        bus_rd = 1'b0;
      end
      step();
    end
    rx     = 1'b1;
    bus_rd = 1'b0;
    model_frame(b, stop_ok);
    if (!stop_ok) repeat (DIV) step();
  endtask

  // Monitor: compares every read response one cycle after its strobe.
  task automatic monitor();
    logic        was_rd;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      was_rd = bus_rd;
      @(negedge clk);
      if (was_rd) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_read: got 0x%08h, expected no response pending", bus_rdata);
        end else begin
          e = exp_q.pop_front();
          check("bus_read", bus_rdata, e);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    int          t_irq;
    logic [7:0]  rb;
    int          act;

    rst_n    = 1'b0;
    rx       = 1'b1;
    bus_rd   = 1'b0;
    bus_addr = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) step();
    check("reset_rdata", bus_rdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Single byte with latency measurement
    t_irq = -1;
    fork
      send_frame(8'h55, 1'b1, -1);
      begin
        for (int n = 0; n < 20 * DIV; n++) begin
          @(negedge clk);
          if (irq) begin
            t_irq = cyc;
            break;
          end
        end
      end
    join
    lat = (t_irq < 0) ? -1 : t_irq - t_frame_start;
    checks++;
    if (lat < 2 + DIV / 2 + 9 * DIV - 1 || lat > 2 + DIV / 2 + 9 * DIV + 1) begin
      errors++;
      $display("FAIL frame_latency: got %0d cycles, expected %0d +/- 1",
               lat, 2 + DIV / 2 + 9 * DIV);
    end
    check("irq_pending", {31'd0, irq}, 32'd1);
    do_read(1'b1);
    do_read(1'b0);
    check("irq_after_pop", {31'd0, irq}, 32'd0);

    // Glitch shorter than half a bit
    rx = 1'b0;
    repeat (3) step();
    rx = 1'b1;
    repeat (2 * DIV) step();
    do_read(1'b1);
    check("irq_after_glitch", {31'd0, irq}, 32'd0);

    // Framing error, then the flag clears on read
    send_frame(8'hA3, 1'b0, -1);
    check("irq_after_ferr", {31'd0, irq}, 32'd0);
    do_read(1'b1);
    do_read(1'b1);

    // Overrun: five bytes into four slots
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, -1);
    do_read(1'b1);
    repeat (3) step();
    check("rdata_hold", bus_rdata, 32'h47);
    for (int i = 0; i < 5; i++) do_read(1'b0);

    // Pop and push on the same edge while full
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, -1);
    send_frame(8'h05, 1'b1, (lat > 0) ? lat : -1);
    do_read(1'b1);
    for (int i = 0; i < 4; i++) do_read(1'b0);

    // Reset during the 4th data bit discards the partial byte
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'h5A, 1'b0};
      for (int k = 0; k < 4 * DIV + DIV / 2; k++) begin
        rx = bits[k / DIV];
        step();
      end
    end
    rst_n = 1'b0;
    rx    = 1'b1;
    mq.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    repeat (3) step();
    check("midframe_reset_rdata", bus_rdata, 32'd0);
    rst_n = 1'b1;
    repeat (2 * DIV) step();
    send_frame(8'hC3, 1'b1, -1);
    do_read(1'b1);
    do_read(1'b0);
    do_read(1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      act = $urandom_range(0, 9);
      if (act <= 5) begin
        rb = 8'($urandom);
        send_frame(rb, ($urandom_range(0, 7) != 0), -1);
      end else if (act <= 7) begin
        do_read(1'b1);
      end else begin
        do_read(1'b0);
      end
      check("irq_level", {31'd0, irq}, (mq.size() != 0) ? 32'd1 : 32'd0);
      repeat ($urandom_range(0, 3)) step();
    end
    do_read(1'b1);
    while (mq.size() > 0) do_read(1'b0);

    repeat (4) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
